// File: rtl/ram_io_responder.sv
// Byte-serial RAM bus responder: a 2^ADDR_WIDTH byte memory plus an IO window
// holding a tx byte FIFO, an rx byte FIFO and a status register.
module ram_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int IO_BIT     = 17,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        ramRW_in,
    input  logic [31:0] ramAddr_in,
    input  logic [7:0]  ramData_in,
    output logic [7:0]  ramData_out,
    output logic [7:0]  txData_out,
    output logic        txValid_out,
    input  logic        txReady_in,
    input  logic [7:0]  rxData_in,
    input  logic        rxValid_in,
    output logic        rxReady_out,
    output logic        txOverflow_out
);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = PW - 1;

    logic [7:0] mem    [0:(1 << ADDR_WIDTH) - 1];
    logic [7:0] tx_buf [0:FIFO_DEPTH - 1];
    logic [7:0] rx_buf [0:FIFO_DEPTH - 1];

    logic [PW-1:0] tx_wp, tx_rp, rx_wp, rx_rp;
    logic          tx_empty, tx_full, rx_empty, rx_full;

    logic                  is_io;
    logic [2:0]            io_off;
    logic [ADDR_WIDTH-1:0] mem_idx;
    logic                  bus_rd, bus_wr, io_port;
    logic                  tx_pop, tx_push_req, tx_push, tx_drop;
    logic                  rx_pop, rx_push;
    logic [7:0]            rd_byte;
    logic                  unused_addr;

    assign unused_addr = ^ramAddr_in;

    assign is_io   = ramAddr_in[IO_BIT];
    assign io_off  = ramAddr_in[2:0];
    assign mem_idx = ramAddr_in[ADDR_WIDTH-1:0];
    assign bus_rd  = rdy_in & ~ramRW_in;
    assign bus_wr  = rdy_in & ramRW_in;
    assign io_port = is_io & (io_off == 3'd0);

    // Full when the wrap bits differ but the index bits match.
    assign tx_empty = (tx_wp == tx_rp);
    assign tx_full  = (tx_wp[PW-1] != tx_rp[PW-1]) && (tx_wp[IW-1:0] == tx_rp[IW-1:0]);
    assign rx_empty = (rx_wp == rx_rp);
    assign rx_full  = (rx_wp[PW-1] != rx_rp[PW-1]) && (rx_wp[IW-1:0] == rx_rp[IW-1:0]);

    assign txValid_out = ~tx_empty;
    assign txData_out  = tx_buf[tx_rp[IW-1:0]];
    assign rxReady_out = ~rx_full;

    // A full tx FIFO still accepts a write when the consumer drains it this cycle.
    assign tx_pop      = ~tx_empty & txReady_in;
    assign tx_push_req = bus_wr & io_port;
    assign tx_push     = tx_push_req & (~tx_full | tx_pop);
    assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
    assign rx_pop      = bus_rd & io_port & ~rx_empty;
    assign rx_push     = rxValid_in & ~rx_full;

    always_comb begin
        rd_byte = 8'h00;
        if (!is_io) begin
            rd_byte = mem[mem_idx];
        end else if (io_off == 3'd0) begin
            if (!rx_empty) rd_byte = rx_buf[rx_rp[IW-1:0]];
        end else if (io_off == 3'd4) begin
            rd_byte = {6'b0, tx_full, ~rx_empty};
        end
    end

    always_ff @(posedge clk_in) begin
        if (bus_wr && !is_io) mem[mem_idx] <= ramData_in;
        if (tx_push) tx_buf[tx_wp[IW-1:0]] <= ramData_in;
        if (rx_push) rx_buf[rx_wp[IW-1:0]] <= rxData_in;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            ramData_out    <= 8'h00;
            txOverflow_out <= 1'b0;
            tx_wp          <= '0;
            tx_rp          <= '0;
            rx_wp          <= '0;
            rx_rp          <= '0;
        end else begin
            if (bus_rd)  ramData_out    <= rd_byte;
            if (tx_drop) txOverflow_out <= 1'b1;
            if (tx_push) tx_wp <= tx_wp + 1'b1;
            if (tx_pop)  tx_rp <= tx_rp + 1'b1;
            if (rx_push) rx_wp <= rx_wp + 1'b1;
            if (rx_pop)  rx_rp <= rx_rp + 1'b1;
        end
    end
endmodule

// File: tb/tb_ram_io_responder.sv
// Scoreboard bench for ram_io_responder: queue models of memory and both FIFOs.
module tb_ram_io_responder;
    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, ramRW_in, txReady_in, rxValid_in;
    logic [31:0] ramAddr_in;
    logic [7:0]  ramData_in, rxData_in;
    logic [7:0]  ramData_out, txData_out;
    logic        txValid_out, rxReady_out, txOverflow_out;

    ram_io_responder #(.ADDR_WIDTH(17), .IO_BIT(17), .FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .ramRW_in(ramRW_in),
        .ramAddr_in(ramAddr_in), .ramData_in(ramData_in), .ramData_out(ramData_out),
        .txData_out(txData_out), .txValid_out(txValid_out), .txReady_in(txReady_in),
        .rxData_in(rxData_in), .rxValid_in(rxValid_in), .rxReady_out(rxReady_out),
        .txOverflow_out(txOverflow_out)
    );

    always #5 clk_in = ~clk_in;

    int         checks = 0;
    int         failures = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] mem_m [int];
    logic       ovf_m = 1'b0;
    logic [7:0] last_rd = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One bus cycle; called just after a rising edge, returns just after the next one.
    task automatic cyc(input logic rdy, input logic rw, input logic [31:0] addr,
                       input logic [7:0] wd, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
        logic       tx_pop, rx_full_m, io;
        logic [2:0] off;
        logic [7:0] dummy;
        rdy_in = rdy; ramRW_in = rw; ramAddr_in = addr; ramData_in = wd;
        txReady_in = txr; rxValid_in = rxv; rxData_in = rxd;
        #1;
        chk("tx_valid", txValid_out, tx_q.size() != 0);
        if (tx_q.size() != 0) chk("tx_head", txData_out, tx_q[0]);
        chk("rx_ready", rxReady_out, rx_q.size() < DEPTH);
        tx_pop    = (tx_q.size() != 0) && txr;
        rx_full_m = (rx_q.size() == DEPTH);
        io        = addr[17];
        off       = addr[2:0];
        if (rdy && !rw) begin
            if (!io) last_rd = mem_m[int'(addr[16:0])];
            else if (off == 3'd0) last_rd = (rx_q.size() != 0) ? rx_q.pop_front() : 8'h00;
            else if (off == 3'd4) last_rd = {6'b0, tx_q.size() == DEPTH, rx_q.size() != 0};
            else last_rd = 8'h00;
        end
        if (tx_pop) dummy = tx_q.pop_front();
        if (rdy && rw) begin
            if (!io) mem_m[int'(addr[16:0])] = wd;
            else if (off == 3'd0) begin
                if (tx_q.size() < DEPTH) tx_q.push_back(wd);
                else ovf_m = 1'b1;
            end
        end
        if (rxv && !rx_full_m) rx_q.push_back(rxd);
        exp_q.push_back(last_rd);
        @(posedge clk_in); #1;
        chk("rdata", ramData_out, exp_q.pop_front());
        chk("tx_ovf", txOverflow_out, ovf_m);
    endtask

    task automatic idle(input logic txr, input logic rxv, input logic [7:0] rxd);
        cyc(1'b0, 1'b0, 32'h0, 8'h00, txr, rxv, rxd);
    endtask

    // Reset asserted between clock edges; outputs must clear before the next edge.
    task automatic mid_reset();
        #2 rst_in = 1'b1;
        #1;
        chk("rst_rdata", ramData_out, 8'h00);
        chk("rst_txvalid", txValid_out, 1'b0);
        chk("rst_rxready", rxReady_out, 1'b1);
        chk("rst_ovf", txOverflow_out, 1'b0);
        rdy_in = 1'b0; txReady_in = 1'b0; rxValid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        tx_q.delete(); rx_q.delete();
        ovf_m = 1'b0; last_rd = 8'h00;
    endtask

    initial begin
        rst_in = 1'b1; rdy_in = 1'b0; ramRW_in = 1'b0; ramAddr_in = 32'h0;
        ramData_in = 8'h00; txReady_in = 1'b0; rxValid_in = 1'b0; rxData_in = 8'h00;
        #12;
        chk("por_rdata", ramData_out, 8'h00);
        chk("por_txvalid", txValid_out, 1'b0);
        chk("por_rxready", rxReady_out, 1'b1);
        chk("por_ovf", txOverflow_out, 1'b0);
        @(posedge clk_in); #1;
        rst_in = 1'b0;

        // Memory write/read and hold during writes.
        cyc(1, 1, 32'h0000_1235, 8'h5A, 0, 0, 0);
        cyc(1, 1, 32'h0000_1234, 8'hA5, 0, 0, 0);
        cyc(1, 0, 32'h0000_1234, 8'h00, 0, 0, 0);
        chk("mem_rd_new", ramData_out, 8'hA5);
        cyc(1, 0, 32'h0000_1235, 8'h00, 0, 0, 0);
        chk("mem_rd_pre", ramData_out, 8'h5A);
        cyc(1, 1, 32'h0000_1236, 8'hEE, 0, 0, 0);
        chk("mem_wr_hold", ramData_out, 8'h5A);

        // tx fill, overflow on the ninth write, then drain.
        for (int i = 0; i < 9; i++) cyc(1, 1, 32'h0003_0000, 8'(8'h41 + i), 0, 0, 0);
        chk("tx_ovf_set", txOverflow_out, 1'b1);
        chk("tx_head41", txData_out, 8'h41);
        cyc(1, 0, 32'h0003_0004, 8'h00, 0, 0, 0);
        chk("tx_status", ramData_out, 8'h02);
        for (int i = 0; i < 8; i++) idle(1, 0, 0);
        chk("tx_drained", txValid_out, 1'b0);
        idle(1, 0, 0);

        // Other IO offsets: reads 0, writes ignored.
        cyc(1, 1, 32'h0003_0001, 8'h99, 0, 0, 0);
        cyc(1, 0, 32'h0003_0002, 8'h00, 0, 0, 0);
        chk("io_other_rd", ramData_out, 8'h00);
        chk("io_other_wr", txValid_out, 1'b0);

        mid_reset();

        // Full tx with a same-cycle drain accepts the write.
        for (int i = 0; i < 8; i++) cyc(1, 1, 32'h0003_0000, 8'(8'h41 + i), 0, 0, 0);
        cyc(1, 1, 32'h0003_0000, 8'h55, 1, 0, 0);
        chk("tx_full_pop_ovf", txOverflow_out, 1'b0);
        for (int i = 0; i < 7; i++) idle(1, 0, 0);
        chk("tx_last55", txData_out, 8'h55);
        idle(1, 0, 0);
        idle(0, 0, 0);

        // rx: three bytes, drain, status, empty read.
        idle(0, 1, 8'h10); idle(0, 1, 8'h20); idle(0, 1, 8'h30);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rx_rd10", ramData_out, 8'h10);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rx_rd30", ramData_out, 8'h30);
        cyc(1, 0, 32'h0003_0004, 0, 0, 0, 0);
        chk("rx_status0", ramData_out, 8'h00);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rx_empty_rd", ramData_out, 8'h00);
        cyc(1, 0, 32'h0003_0000, 0, 0, 1, 8'h77);
        chk("rx_rd_concurrent", ramData_out, 8'h00);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rx_rd77", ramData_out, 8'h77);

        // rx full, rejected byte, pop plus push, order.
        for (int i = 0; i < 8; i++) idle(0, 1, 8'(8'h81 + i));
        chk("rx_full_ready", rxReady_out, 1'b0);
        idle(0, 1, 8'hF9);
        cyc(1, 0, 32'h0003_0000, 0, 0, 1, 8'h89);
        chk("rx_pop81", ramData_out, 8'h81);
        cyc(1, 0, 32'h0003_0000, 0, 0, 1, 8'h89);
        chk("rx_pushpop_ready", rxReady_out, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rx_order_last", ramData_out, 8'h89);

        // rdy_in low with a pending IO read: no pop, data holds.
        idle(0, 1, 8'hC1);
        cyc(0, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rdy0_hold", ramData_out, 8'h89);
        cyc(1, 0, 32'h0003_0000, 0, 0, 0, 0);
        chk("rdy0_nopop", ramData_out, 8'hC1);

        // Reset in the middle of a burst.
        cyc(1, 1, 32'h0003_0000, 8'h61, 0, 1, 8'hD1);
        cyc(1, 1, 32'h0003_0000, 8'h62, 0, 0, 0);
        cyc(1, 0, 32'h0000_1234, 0, 0, 0, 0);
        mid_reset();
        cyc(1, 0, 32'h0003_0004, 0, 0, 0, 0);
        chk("post_rst_status", ramData_out, 8'h00);
        cyc(1, 1, 32'h0003_0000, 8'h71, 0, 0, 0);
        chk("post_rst_tx", txData_out, 8'h71);
        idle(1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
